z_writeback_seq: RTL and testbench

//  Downstream stage of the ALU. Captures the 64-bit ALU result into the Z register pair (ZHI:ZLO).

---
 rtl/z_writeback_seq.sv | 91 +++++++++
 tb/tb_z_writeback_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/z_writeback_seq.sv
// Z register pair capture and one/two-word writeback sequencer between the ALU and the register file.
// Multiply and divide results go out as LO then HI; every other opcode writes back a single LO word.
module z_writeback_seq #(
  parameter int unsigned DATA_W = 32,
  parameter logic [4:0]  MUL_OP = 5'b01111,
  parameter logic [4:0]  DIV_OP = 5'b10000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_result,
  input  logic [4:0]            in_opcode,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_hi,
  output logic [DATA_W-1:0]     zhi_q,
  output logic [DATA_W-1:0]     zlo_q,
  output logic [CNT_W-1:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t state;
  logic   two_word;

  always_comb begin
    in_ready = (state == IDLE);
  end

  // wb_data is loaded one step ahead of each state so it is a pure register output.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      two_word <= 1'b0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_hi    <= 1'b0;
      ops_done <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            zhi_q    <= in_result[2*DATA_W-1:DATA_W];
            zlo_q    <= in_result[DATA_W-1:0];
            two_word <= (in_opcode == MUL_OP) || (in_opcode == DIV_OP);
            wb_valid <= 1'b1;
            wb_data  <= in_result[DATA_W-1:0];
            wb_hi    <= 1'b0;
            state    <= WR_LO;
          end
        end
        WR_LO: begin
          if (wb_ready) begin
            if (two_word) begin
              wb_data <= zhi_q;
              wb_hi   <= 1'b1;
              state   <= WR_HI;
            end else begin
              wb_valid <= 1'b0;
              ops_done <= ops_done + CNT_W'(1);
              state    <= IDLE;
            end
          end
        end
        WR_HI: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            wb_hi    <= 1'b0;
            ops_done <= ops_done + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          wb_hi    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_writeback_seq.sv
// Bench for z_writeback_seq: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a word-queue model of the writeback stream.
module tb_z_writeback_seq;

  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_result = '0;
  logic [4:0]  in_opcode = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic        wb_hi;
  logic [31:0] zhi_q, zlo_q;
  logic [15:0] ops_done;

  // narrow-counter instance shares the stimulus so counter wrap is reachable in a short run
  logic        in_ready4, wb_valid4, wb_hi4;
  logic [31:0] wb_data4, zhi_q4, zlo_q4;
  logic [3:0]  ops_done4;

  int unsigned tests = 0;
  int unsigned fails = 0;

  z_writeback_seq #(.DATA_W(32), .MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_opcode(in_opcode), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_hi(wb_hi), .zhi_q(zhi_q), .zlo_q(zlo_q), .ops_done(ops_done)
  );

  z_writeback_seq #(.DATA_W(32), .MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .CNT_W(4)) dut4 (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
    .in_result(in_result), .in_opcode(in_opcode), .wb_valid(wb_valid4), .wb_ready(wb_ready),
    .wb_data(wb_data4), .wb_hi(wb_hi4), .zhi_q(zhi_q4), .zlo_q(zlo_q4), .ops_done(ops_done4)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending words as {hi, data}; the stage is busy exactly while words remain.
  logic [32:0]  q[$];
  logic [31:0]  m_zhi = '0, m_zlo = '0;
  int unsigned  m_cnt = 0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      q.delete();
      m_zhi = '0;
      m_zlo = '0;
      m_cnt = 0;
    end else if (q.size() == 0) begin
      if (in_valid) begin
        m_zhi = in_result[63:32];
        m_zlo = in_result[31:0];
        q.push_back({1'b0, in_result[31:0]});
        if (in_opcode == MUL_OP || in_opcode == DIV_OP)
          q.push_back({1'b1, in_result[63:32]});
      end
    end else if (wb_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) m_cnt++;
    end
  end

  always @(negedge clock) begin
    if (!clear) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, q.size() == 0});
      check("wb_valid", {63'd0, wb_valid}, {63'd0, q.size() != 0});
      check("wb_valid4", {63'd0, wb_valid4}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        check("wb_data", {32'd0, wb_data}, {32'd0, q[0][31:0]});
        check("wb_hi", {63'd0, wb_hi}, {63'd0, q[0][32]});
      end
      check("zhi_q", {32'd0, zhi_q}, {32'd0, m_zhi});
      check("zlo_q", {32'd0, zlo_q}, {32'd0, m_zlo});
      check("ops_done", {48'd0, ops_done}, {48'd0, m_cnt[15:0]});
      check("ops_done4", {60'd0, ops_done4}, {60'd0, m_cnt[3:0]});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input logic [63:0] res, input logic [4:0] op, input logic rdy);
    in_valid  = 1'b1;
    in_result = res;
    in_opcode = op;
    wb_ready  = rdy;
    cyc();
    in_valid  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2 clear = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_ops_done", {48'd0, ops_done}, 64'd0);
    check("rst_zhi", {32'd0, zhi_q}, 64'd0);
    cyc();

    // clear pulse while LO word is stalled
    issue(64'hAAAA_BBBB_CCCC_DDDD, MUL_OP, 1'b0);
    @(negedge clock);
    check("mid_wb_valid", {63'd0, wb_valid}, 64'd1);
    #1 clear = 1'b1;
    #2 clear = 1'b0;
    @(negedge clock);
    check("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("midrst_zlo", {32'd0, zlo_q}, 64'd0);
    check("midrst_ops_done", {48'd0, ops_done}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    cyc();
    wb_ready = 1'b1;
    cyc();
    @(negedge clock);
    check("midrst_no_hi", {63'd0, wb_valid}, 64'd0);
    cyc();

    // add: single word
    issue(64'h0000_0000_0000_0007, 5'b00011, 1'b1);
    @(negedge clock);
    check("add_data", {32'd0, wb_data}, 64'h7);
    check("add_hi", {63'd0, wb_hi}, 64'd0);
    check("add_busy", {63'd0, in_ready}, 64'd0);
    cyc();
    @(negedge clock);
    check("add_ready", {63'd0, in_ready}, 64'd1);
    check("add_ops", {48'd0, ops_done}, 64'd1);
    cyc();

    // multiply: LO then HI on consecutive cycles
    issue(64'h0000_0001_8000_0000, MUL_OP, 1'b1);
    @(negedge clock);
    check("mul_lo", {31'd0, wb_hi, wb_data}, 64'h0_8000_0000);
    cyc();
    @(negedge clock);
    check("mul_hi", {31'd0, wb_hi, wb_data}, 64'h1_0000_0001);
    check("mul_valid", {63'd0, wb_valid}, 64'd1);
    cyc();
    @(negedge clock);
    check("mul_ops", {48'd0, ops_done}, 64'd2);

    // divide with backpressure, then input toggling while HI is stalled
    cyc();
    issue({32'd2, 32'd5}, DIV_OP, 1'b0);
    repeat (3) begin
      @(negedge clock);
      check("div_hold", {31'd0, wb_hi, wb_data}, 64'h0_0000_0005);
      check("div_busy", {63'd0, in_ready}, 64'd0);
      cyc();
    end
    wb_ready = 1'b1;
    @(negedge clock);
    check("div_lo", {31'd0, wb_hi, wb_data}, 64'h0_0000_0005);
    cyc();
    wb_ready  = 1'b0;
    in_valid  = 1'b1;
    in_result = 64'hDEAD_BEEF_1234_5678;
    in_opcode = MUL_OP;
    @(negedge clock);
    check("div_hi", {31'd0, wb_hi, wb_data}, 64'h1_0000_0002);
    cyc();
    in_result = 64'h0F0F_0F0F_F0F0_F0F0;
    @(negedge clock);
    check("ign_zhi", {32'd0, zhi_q}, 64'd2);
    check("ign_zlo", {32'd0, zlo_q}, 64'd5);
    check("ign_ops", {48'd0, ops_done}, 64'd2);
    cyc();
    in_valid = 1'b0;
    wb_ready = 1'b1;
    cyc();
    @(negedge clock);
    check("div_ops", {48'd0, ops_done}, 64'd3);
    cyc();

    // 13 more retirements: 16 total wraps the 4-bit counter; unknown opcode counts as one word
    for (int i = 0; i < 13; i++) begin
      issue(64'(i), (i == 0) ? 5'b11111 : 5'b00001, 1'b1);
      cyc();
    end
    @(negedge clock);
    check("wrap_ops16", {48'd0, ops_done}, 64'd16);
    check("wrap_ops4", {60'd0, ops_done4}, 64'd0);
    cyc();

    for (int i = 0; i < 4000; i++) begin
      int unsigned sel;
      in_valid = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 3);
      in_opcode = (sel == 0) ? MUL_OP : (sel == 1) ? DIV_OP : 5'($urandom);
      in_result = {($urandom_range(0, 1) != 0) ? $urandom : 32'd0, $urandom};
      wb_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clock);
        #1 clear = 1'b1;
        #2 clear = 1'b0;
      end
      cyc();
    end

    in_valid = 1'b0;
    wb_ready = 1'b1;
    repeat (5) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
